alu_issue_stage: RTL and testbench

ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

---
 rtl/alu_issue_stage.sv | 248 ++++++++++++++++++++++++
 tb/tb_alu_issue_stage.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
`default_nettype none
// ============================================================================
//  Module   : alu_issue_stage
//  Purpose  : ID->EX pipeline register for a small RV32I-style integer core.
//             Decodes the ALU operation and control bits from the ID fields,
//             registers them into EX, detects load-use hazards against the
//             instruction in EX, and forwards EX/MEM and MEM/WB results into
//             the ALU operands and the store data.
//  Ports    : clk, reset            - clock, synchronous active-high reset
//             id_*                  - instruction fields and operands in ID
//             exmem_*, memwb_*      - forwarding sources from later stages
//             stall, flush          - pipeline hold / kill of EX register
//             hazard_stall          - load-use stall request (combinational)
//             ex_*, alu_*           - EX register contents and ALU operands
//  Revision : 1.0 - initial release
// ============================================================================
module alu_issue_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        id_valid,
    input  logic [6:0]  id_opcode,
    input  logic [2:0]  id_funct3,
    input  logic        id_funct7_b5,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic [4:0]  id_rd,
    input  logic [31:0] id_rs1_data,
    input  logic [31:0] id_rs2_data,
    input  logic [31:0] id_imm,
    input  logic        exmem_reg_write,
    input  logic [4:0]  exmem_rd,
    input  logic [31:0] exmem_result,
    input  logic        memwb_reg_write,
    input  logic [4:0]  memwb_rd,
    input  logic [31:0] memwb_result,
    input  logic        stall,
    input  logic        flush,
    output logic        hazard_stall,
    output logic        ex_valid,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_control,
    output logic [31:0] ex_store_data,
    output logic [4:0]  ex_rd,
    output logic        ex_reg_write,
    output logic        ex_mem_read,
    output logic        ex_mem_write,
    output logic        ex_branch,
    output logic        ex_illegal
);

    localparam logic [6:0] c_OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] c_OP_IALU   = 7'b0010011;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;

    localparam logic [3:0] c_ALU_AND = 4'b0000;
    localparam logic [3:0] c_ALU_OR  = 4'b0001;
    localparam logic [3:0] c_ALU_ADD = 4'b0010;
    localparam logic [3:0] c_ALU_SUB = 4'b0110;

    // ------------------------------------------------------------------
    // EX register
    // ------------------------------------------------------------------
    logic        r_valid;
    logic [4:0]  r_rs1;
    logic [4:0]  r_rs2;
    logic [4:0]  r_rd;
    logic [31:0] r_rs1_data;
    logic [31:0] r_rs2_data;
    logic [31:0] r_imm;
    logic [3:0]  r_alu_control;
    logic        r_alu_src;
    logic        r_reg_write;
    logic        r_mem_read;
    logic        r_mem_write;
    logic        r_branch;
    logic        r_illegal;

    // ------------------------------------------------------------------
    // Decode of the ID instruction
    // ------------------------------------------------------------------
    logic [3:0] w_alu_control;
    logic       w_alu_src;
    logic       w_reg_write;
    logic       w_mem_read;
    logic       w_mem_write;
    logic       w_branch;
    logic       w_illegal;

    always_comb begin
        w_alu_control = c_ALU_ADD;
        w_alu_src     = 1'b0;
        w_reg_write   = 1'b0;
        w_mem_read    = 1'b0;
        w_mem_write   = 1'b0;
        w_branch      = 1'b0;
        w_illegal     = 1'b0;
        case (id_opcode)
            c_OP_RTYPE: begin
                case (id_funct3)
                    3'b000: begin
                        w_alu_control = id_funct7_b5 ? c_ALU_SUB : c_ALU_ADD;
                        w_reg_write   = 1'b1;
                    end
                    3'b111: begin
                        w_alu_control = c_ALU_AND;
                        w_reg_write   = 1'b1;
                    end
                    3'b110: begin
                        w_alu_control = c_ALU_OR;
                        w_reg_write   = 1'b1;
                    end
                    default: w_illegal = 1'b1;
                endcase
            end
            c_OP_IALU: begin
                case (id_funct3)
                    3'b000: begin
                        w_alu_src   = 1'b1;
                        w_reg_write = 1'b1;
                    end
                    3'b111: begin
                        w_alu_control = c_ALU_AND;
                        w_alu_src     = 1'b1;
                        w_reg_write   = 1'b1;
                    end
                    3'b110: begin
                        w_alu_control = c_ALU_OR;
                        w_alu_src     = 1'b1;
                        w_reg_write   = 1'b1;
                    end
                    default: w_illegal = 1'b1;
                endcase
            end
            c_OP_LOAD: begin
                w_alu_src   = 1'b1;
                w_mem_read  = 1'b1;
                w_reg_write = 1'b1;
            end
            c_OP_STORE: begin
                w_alu_src   = 1'b1;
                w_mem_write = 1'b1;
            end
            c_OP_BRANCH: begin
                w_alu_control = c_ALU_SUB;
                w_branch      = 1'b1;
            end
            default: w_illegal = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // Load-use hazard: rs2 only matters for formats that actually read it
    // (R-type, store, branch); I-type reuses those bits as immediate.
    // ------------------------------------------------------------------
    logic w_uses_rs2;
    logic w_hazard;

    assign w_uses_rs2 = (id_opcode == c_OP_RTYPE) || (id_opcode == c_OP_STORE) ||
                        (id_opcode == c_OP_BRANCH);
    assign w_hazard   = r_valid && r_mem_read && id_valid && (r_rd != 5'd0) &&
                        ((r_rd == id_rs1) || ((r_rd == id_rs2) && w_uses_rs2));
    assign hazard_stall = w_hazard;

    // ------------------------------------------------------------------
    // Register update: reset > flush > stall > hazard bubble > capture.
    // A bubble only needs to kill valid and the side-effecting controls;
    // the data fields are left as they were.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid       <= 1'b0;
            r_rs1         <= 5'd0;
            r_rs2         <= 5'd0;
            r_rd          <= 5'd0;
            r_rs1_data    <= 32'd0;
            r_rs2_data    <= 32'd0;
            r_imm         <= 32'd0;
            r_alu_control <= c_ALU_ADD;
            r_alu_src     <= 1'b0;
            r_reg_write   <= 1'b0;
            r_mem_read    <= 1'b0;
            r_mem_write   <= 1'b0;
            r_branch      <= 1'b0;
            r_illegal     <= 1'b0;
        end else if (flush || (!stall && w_hazard)) begin
            r_valid     <= 1'b0;
            r_reg_write <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_branch    <= 1'b0;
            r_illegal   <= 1'b0;
        end else if (!stall) begin
            r_valid       <= id_valid;
            r_rs1         <= id_rs1;
            r_rs2         <= id_rs2;
            r_rd          <= id_rd;
            r_rs1_data    <= id_rs1_data;
            r_rs2_data    <= id_rs2_data;
            r_imm         <= id_imm;
            r_alu_control <= w_alu_control;
            r_alu_src     <= w_alu_src;
            r_reg_write   <= w_reg_write;
            r_mem_read    <= w_mem_read;
            r_mem_write   <= w_mem_write;
            r_branch      <= w_branch;
            r_illegal     <= w_illegal;
        end
    end

    // ------------------------------------------------------------------
    // Operand forwarding: the younger EX/MEM result wins over MEM/WB;
    // x0 is never forwarded.
    // ------------------------------------------------------------------
    logic [31:0] w_fwd_rs1;
    logic [31:0] w_fwd_rs2;

    always_comb begin
        w_fwd_rs1 = r_rs1_data;
        if (exmem_reg_write && (exmem_rd != 5'd0) && (exmem_rd == r_rs1))
            w_fwd_rs1 = exmem_result;
        else if (memwb_reg_write && (memwb_rd != 5'd0) && (memwb_rd == r_rs1))
            w_fwd_rs1 = memwb_result;

        w_fwd_rs2 = r_rs2_data;
        if (exmem_reg_write && (exmem_rd != 5'd0) && (exmem_rd == r_rs2))
            w_fwd_rs2 = exmem_result;
        else if (memwb_reg_write && (memwb_rd != 5'd0) && (memwb_rd == r_rs2))
            w_fwd_rs2 = memwb_result;
    end

    assign alu_a         = w_fwd_rs1;
    assign alu_b         = r_alu_src ? r_imm : w_fwd_rs2;
    assign ex_store_data = w_fwd_rs2;

    assign ex_valid      = r_valid;
    assign alu_control   = r_alu_control;
    assign ex_rd         = r_rd;
    assign ex_reg_write  = r_reg_write;
    assign ex_mem_read   = r_mem_read;
    assign ex_mem_write  = r_mem_write;
    assign ex_branch     = r_branch;
    assign ex_illegal    = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_issue_stage
//  Purpose  : Self-checking bench for alu_issue_stage: directed scenarios
//             followed by a randomized run against a behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_issue_stage;

    localparam logic [6:0] c_R  = 7'b0110011;
    localparam logic [6:0] c_I  = 7'b0010011;
    localparam logic [6:0] c_LD = 7'b0000011;
    localparam logic [6:0] c_ST = 7'b0100011;
    localparam logic [6:0] c_BR = 7'b1100011;

    logic        clk = 1'b0;
    logic        reset, id_valid, id_funct7_b5;
    logic [6:0]  id_opcode;
    logic [2:0]  id_funct3;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [31:0] id_rs1_data, id_rs2_data, id_imm;
    logic        exmem_reg_write, memwb_reg_write;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [31:0] exmem_result, memwb_result;
    logic        stall, flush;
    logic        hazard_stall, ex_valid;
    logic [31:0] alu_a, alu_b, ex_store_data;
    logic [3:0]  alu_control;
    logic [4:0]  ex_rd;
    logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_illegal;

    int n_cmp = 0;
    int n_err = 0;

    alu_issue_stage dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_opcode(id_opcode), .id_funct3(id_funct3),
        .id_funct7_b5(id_funct7_b5), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .stall(stall), .flush(flush), .hazard_stall(hazard_stall), .ex_valid(ex_valid),
        .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
        .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_branch(ex_branch), .ex_illegal(ex_illegal)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Behavioural model of what the EX stage should hold
    // ------------------------------------------------------------------
    typedef struct packed {
        logic        valid;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] d1, d2, imm;
        logic [3:0]  ctl;
        logic        src, rw, mr, mw, br, ill;
    } ex_t;

    ex_t m;

    function automatic ex_t model_reset();
        ex_t e = '0;
        e.ctl = 4'b0010;
        return e;
    endfunction

    // Instruction semantics from the ISA table
    function automatic ex_t model_decode();
        ex_t e = '0;
        e.valid = id_valid; e.rs1 = id_rs1; e.rs2 = id_rs2; e.rd = id_rd;
        e.d1 = id_rs1_data; e.d2 = id_rs2_data; e.imm = id_imm;
        e.ctl = 4'b0010;
        if ((id_opcode == c_R || id_opcode == c_I) &&
            (id_funct3 == 3'b000 || id_funct3 == 3'b111 || id_funct3 == 3'b110)) begin
            e.rw  = 1'b1;
            e.src = (id_opcode == c_I);
            if (id_funct3 == 3'b111)      e.ctl = 4'b0000;
            else if (id_funct3 == 3'b110) e.ctl = 4'b0001;
            else if (id_opcode == c_R && id_funct7_b5) e.ctl = 4'b0110;
        end else if (id_opcode == c_LD) begin
            e.src = 1'b1; e.mr = 1'b1; e.rw = 1'b1;
        end else if (id_opcode == c_ST) begin
            e.src = 1'b1; e.mw = 1'b1;
        end else if (id_opcode == c_BR) begin
            e.ctl = 4'b0110; e.br = 1'b1;
        end else begin
            e.ill = 1'b1;
        end
        return e;
    endfunction

    function automatic logic model_hazard(input ex_t e);
        logic reads_rs2 = (id_opcode == c_R) || (id_opcode == c_ST) || (id_opcode == c_BR);
        return e.valid && e.mr && id_valid && (e.rd != 0) &&
               ((e.rd == id_rs1) || (reads_rs2 && e.rd == id_rs2));
    endfunction

    function automatic ex_t model_bubble(input ex_t e);
        ex_t b = e;
        b.valid = 0; b.rw = 0; b.mr = 0; b.mw = 0; b.br = 0; b.ill = 0;
        return b;
    endfunction

    function automatic ex_t model_next(input ex_t e);
        if (reset)             return model_reset();
        if (flush)             return model_bubble(e);
        if (stall)             return e;
        if (model_hazard(e))   return model_bubble(e);
        return model_decode();
    endfunction

    function automatic logic [31:0] model_fwd(input logic [4:0] idx, input logic [31:0] reg_val);
        if (idx == 0) return reg_val;
        if (exmem_reg_write && exmem_rd == idx) return exmem_result;
        if (memwb_reg_write && memwb_rd == idx) return memwb_result;
        return reg_val;
    endfunction

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        reset = 0; stall = 0; flush = 0;
        id_valid = 0; id_opcode = c_R; id_funct3 = 0; id_funct7_b5 = 0;
        id_rs1 = 0; id_rs2 = 0; id_rd = 0;
        id_rs1_data = 0; id_rs2_data = 0; id_imm = 0;
        exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
        memwb_reg_write = 0; memwb_rd = 0; memwb_result = 0;
    endtask

    task automatic drive_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                               input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                               input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm);
        id_valid = 1; id_opcode = op; id_funct3 = f3; id_funct7_b5 = f7;
        id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_rs1_data = d1; id_rs2_data = d2; id_imm = imm;
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        clear_inputs();
        reset = 1; stall = 1; flush = 1;
        drive_instr(c_LD, 3'b010, 1'b0, 5'd3, 5'd4, 5'd3, 32'h55, 32'h66, 32'h77);
        tick();
        tick();
        reset = 0; flush = 0; stall = 0;
        n_cmp++; if (ex_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", ex_valid); end
        n_cmp++; if (alu_control !== 4'b0010) begin n_err++; $display("FAIL reset_aluctl: got %b expected 0010", alu_control); end
        n_cmp++; if ({ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_illegal} !== 5'b0) begin
            n_err++; $display("FAIL reset_ctrl: got %b expected 00000",
                              {ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_illegal}); end
        n_cmp++; if (alu_a !== 32'd0) begin n_err++; $display("FAIL reset_alu_a: got %h expected 0", alu_a); end
        n_cmp++; if (ex_rd !== 5'd0 || ex_store_data !== 32'd0) begin
            n_err++; $display("FAIL reset_data: got rd=%0d sd=%h expected 0/0", ex_rd, ex_store_data); end
        // ID now holds a load-dependent pattern but EX holds no load
        n_cmp++; if (hazard_stall !== 1'b0) begin n_err++; $display("FAIL reset_hazard: got %b expected 0", hazard_stall); end
    endtask

    task automatic test_rtype_sub();
        clear_inputs();
        drive_instr(c_R, 3'b000, 1'b1, 5'd1, 5'd2, 5'd3, 32'd10, 32'd3, 32'hFFFF_FF00);
        tick();
        id_valid = 0;
        n_cmp++; if (alu_control !== 4'b0110) begin n_err++; $display("FAIL sub_aluctl: got %b expected 0110", alu_control); end
        n_cmp++; if (alu_a !== 32'd10) begin n_err++; $display("FAIL sub_alu_a: got %0d expected 10", alu_a); end
        n_cmp++; if (alu_b !== 32'd3) begin n_err++; $display("FAIL sub_alu_b: got %0d expected 3", alu_b); end
        n_cmp++; if (ex_reg_write !== 1'b1 || ex_valid !== 1'b1) begin
            n_err++; $display("FAIL sub_rw_valid: got %b%b expected 11", ex_reg_write, ex_valid); end
        n_cmp++; if (ex_store_data !== 32'd3 || ex_rd !== 5'd3) begin
            n_err++; $display("FAIL sub_sd_rd: got %h/%0d expected 3/3", ex_store_data, ex_rd); end
    endtask

    task automatic test_forward_priority();
        clear_inputs();
        drive_instr(c_R, 3'b000, 1'b0, 5'd5, 5'd6, 5'd8, 32'h11, 32'h22, 32'h0);
        tick();
        stall = 1;
        exmem_reg_write = 1; exmem_rd = 5; exmem_result = 32'hAA;
        memwb_reg_write = 1; memwb_rd = 5; memwb_result = 32'hBB;
        #1;
        n_cmp++; if (alu_a !== 32'hAA) begin n_err++; $display("FAIL fwd_exmem: got %h expected aa", alu_a); end
        n_cmp++; if (alu_b !== 32'h22) begin n_err++; $display("FAIL fwd_nomatch_b: got %h expected 22", alu_b); end
        exmem_reg_write = 0;
        #1;
        n_cmp++; if (alu_a !== 32'hBB) begin n_err++; $display("FAIL fwd_memwb: got %h expected bb", alu_a); end
        memwb_rd = 6;
        #1;
        n_cmp++; if (ex_store_data !== 32'hBB || alu_a !== 32'h11) begin
            n_err++; $display("FAIL fwd_rs2: got sd=%h a=%h expected bb/11", ex_store_data, alu_a); end
        stall = 0;
        drive_instr(c_R, 3'b000, 1'b0, 5'd0, 5'd0, 5'd8, 32'h33, 32'h44, 32'h0);
        exmem_reg_write = 1; exmem_rd = 0; memwb_reg_write = 1; memwb_rd = 0;
        tick();
        id_valid = 0;
        n_cmp++; if (alu_a !== 32'h33) begin n_err++; $display("FAIL fwd_x0: got %h expected 33", alu_a); end
        n_cmp++; if (alu_b !== 32'h44) begin n_err++; $display("FAIL fwd_x0_b: got %h expected 44", alu_b); end
    endtask

    task automatic test_load_use();
        clear_inputs();
        drive_instr(c_LD, 3'b010, 1'b0, 5'd1, 5'd0, 5'd7, 32'd100, 32'd0, 32'd4);
        tick();
        drive_instr(c_R, 3'b000, 1'b0, 5'd7, 5'd2, 5'd1, 32'hDEAD, 32'd5, 32'd0);
        #1;
        n_cmp++; if (hazard_stall !== 1'b1) begin n_err++; $display("FAIL lu_hazard: got %b expected 1", hazard_stall); end
        tick();
        n_cmp++; if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || ex_mem_read !== 1'b0) begin
            n_err++; $display("FAIL lu_bubble: got v=%b rw=%b mr=%b expected 000", ex_valid, ex_reg_write, ex_mem_read); end
        n_cmp++; if (hazard_stall !== 1'b0) begin n_err++; $display("FAIL lu_hazard_clear: got %b expected 0", hazard_stall); end
        memwb_reg_write = 1; memwb_rd = 7; memwb_result = 32'h1234;
        tick();
        id_valid = 0;
        n_cmp++; if (ex_valid !== 1'b1 || alu_a !== 32'h1234 || alu_b !== 32'd5 || ex_rd !== 5'd1) begin
            n_err++; $display("FAIL lu_add: got v=%b a=%h b=%h rd=%0d expected 1/1234/5/1",
                              ex_valid, alu_a, alu_b, ex_rd); end
        memwb_reg_write = 0;
        // load into x0 never stalls
        drive_instr(c_LD, 3'b010, 1'b0, 5'd1, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0);
        tick();
        drive_instr(c_R, 3'b000, 1'b0, 5'd0, 5'd0, 5'd2, 32'd0, 32'd0, 32'd0);
        #1;
        n_cmp++; if (hazard_stall !== 1'b0) begin n_err++; $display("FAIL lu_x0: got %b expected 0", hazard_stall); end
        drive_instr(c_LD, 3'b010, 1'b0, 5'd1, 5'd0, 5'd7, 32'd0, 32'd0, 32'd0);
        tick();
        // I-type rs2 field is immediate, not a register read
        drive_instr(c_I, 3'b000, 1'b0, 5'd3, 5'd7, 5'd2, 32'd0, 32'd0, 32'd7);
        #1;
        n_cmp++; if (hazard_stall !== 1'b0) begin n_err++; $display("FAIL lu_itype_rs2: got %b expected 0", hazard_stall); end
        drive_instr(c_ST, 3'b010, 1'b0, 5'd3, 5'd7, 5'd0, 32'd0, 32'd0, 32'd0);
        #1;
        n_cmp++; if (hazard_stall !== 1'b1) begin n_err++; $display("FAIL lu_store_rs2: got %b expected 1", hazard_stall); end
        stall = 1; flush = 1;
        #1;
        n_cmp++; if (hazard_stall !== 1'b1) begin n_err++; $display("FAIL lu_unmasked: got %b expected 1", hazard_stall); end
        stall = 0; flush = 0;
        id_valid = 0;
        #1;
        n_cmp++; if (hazard_stall !== 1'b0) begin n_err++; $display("FAIL lu_idinvalid: got %b expected 0", hazard_stall); end
        tick();
    endtask

    task automatic test_stall_flush();
        clear_inputs();
        drive_instr(c_R, 3'b110, 1'b0, 5'd1, 5'd2, 5'd9, 32'hF0, 32'h0F, 32'h0);
        tick();
        stall = 1;
        drive_instr(c_I, 3'b111, 1'b0, 5'd3, 5'd4, 5'd4, 32'h12, 32'h34, 32'h56);
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (alu_control !== 4'b0001 || alu_a !== 32'hF0 || alu_b !== 32'h0F ||
                         ex_rd !== 5'd9 || ex_valid !== 1'b1 || ex_reg_write !== 1'b1) begin
                n_err++; $display("FAIL stall_hold%0d: got ctl=%b a=%h b=%h rd=%0d v=%b rw=%b expected 0001/f0/0f/9/1/1",
                                  i, alu_control, alu_a, alu_b, ex_rd, ex_valid, ex_reg_write); end
        end
        flush = 1;
        tick();
        stall = 0; flush = 0;
        n_cmp++; if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0) begin
            n_err++; $display("FAIL flush_bubble: got v=%b rw=%b expected 00", ex_valid, ex_reg_write); end
        drive_instr(7'b1111111, 3'b000, 1'b0, 5'd1, 5'd2, 5'd3, 32'd1, 32'd2, 32'd3);
        tick();
        id_valid = 0;
        n_cmp++; if (ex_illegal !== 1'b1 || ex_reg_write !== 1'b0 || alu_control !== 4'b0010 || ex_valid !== 1'b1) begin
            n_err++; $display("FAIL illegal: got ill=%b rw=%b ctl=%b v=%b expected 1/0/0010/1",
                              ex_illegal, ex_reg_write, alu_control, ex_valid); end
    endtask

    task automatic test_random();
        logic [6:0] ops [7];
        logic [4:0] exp_ctrl;
        logic [31:0] ea, eb, es;
        ops[0] = c_R; ops[1] = c_I; ops[2] = c_LD; ops[3] = c_ST;
        ops[4] = c_BR; ops[5] = 7'b1111111; ops[6] = 7'b0110111;
        clear_inputs();
        reset = 1;
        tick();
        m = model_reset();
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 49) == 0);
            stall = ($urandom_range(0, 7) == 0);
            flush = ($urandom_range(0, 9) == 0);
            id_valid = ($urandom_range(0, 5) != 0);
            id_opcode = ops[$urandom_range(0, 6)];
            id_funct3 = 3'($urandom);
            id_funct7_b5 = 1'($urandom);
            id_rs1 = 5'($urandom_range(0, 3));
            id_rs2 = 5'($urandom_range(0, 3));
            id_rd  = 5'($urandom_range(0, 3));
            id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
            exmem_reg_write = 1'($urandom); exmem_rd = 5'($urandom_range(0, 3)); exmem_result = $urandom;
            memwb_reg_write = 1'($urandom); memwb_rd = 5'($urandom_range(0, 3)); memwb_result = $urandom;
            #1;
            n_cmp++; if (hazard_stall !== model_hazard(m)) begin
                n_err++; $display("FAIL rnd_hazard[%0d]: got %b expected %b", i, hazard_stall, model_hazard(m)); end
            exp_ctrl = {m.rw, m.mr, m.mw, m.br, m.ill};
            n_cmp++; if (ex_valid !== m.valid ||
                         {ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_illegal} !== exp_ctrl) begin
                n_err++; $display("FAIL rnd_ctrl[%0d]: got v=%b c=%b expected v=%b c=%b", i, ex_valid,
                                  {ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_illegal}, m.valid, exp_ctrl); end
            if (m.valid) begin
                ea = model_fwd(m.rs1, m.d1);
                es = model_fwd(m.rs2, m.d2);
                eb = m.src ? m.imm : es;
                n_cmp++; if (alu_a !== ea || alu_b !== eb || ex_store_data !== es ||
                             alu_control !== m.ctl || ex_rd !== m.rd) begin
                    n_err++; $display("FAIL rnd_data[%0d]: got a=%h b=%h sd=%h ctl=%b rd=%0d expected a=%h b=%h sd=%h ctl=%b rd=%0d",
                                      i, alu_a, alu_b, ex_store_data, alu_control, ex_rd, ea, eb, es, m.ctl, m.rd); end
            end
            m = model_next(m);
            tick();
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_rtype_sub();
        test_forward_priority();
        test_load_use();
        test_stall_flush();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
